instr_decode_seq: RTL

//  Instruction decoder and multicycle sequencer that drives ALUandRF: accepts one 16-bit instruction per handshake,

---
 rtl/instr_decode_seq.sv | 111 +++++++++++
 1 files changed

// File: rtl/instr_decode_seq.sv
// Instruction decoder and four-state sequencer that drives ALUandRF control inputs.
// Accepts one 16-bit instruction per handshake and pulses regWrite three cycles later.
module instr_decode_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             instrValid,
  input  logic [WIDTH-1:0] instruction,
  output logic             instrReady,
  output logic [3:0]       srcAddr,
  output logic [3:0]       dstAddr,
  output logic [WIDTH-1:0] immd,
  output logic             rTypeInstruction,
  output logic             shiftInstruction,
  output logic             pcInstruction,
  output logic             flagSet,
  output logic             copyInstruction,
  output logic [2:0]       aluOp,
  output logic             regWrite,
  output logic             illegal
);

  typedef enum logic [1:0] {IDLE, DECODE, EXECUTE, WRITEBACK} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] instr_reg;
  logic [3:0]       op, ext, op_code;
  logic             dec_shift, dec_rtype, dec_flag, dec_copy, dec_legal;
  logic [2:0]       dec_alu;
  logic [WIDTH-1:0] dec_immd;

  assign pcInstruction = 1'b0;

  // Decode works only on the latched word, so a changing input bus never reaches the RF.
  always_comb begin
    op        = instr_reg[15:12];
    ext       = instr_reg[7:4];
    dec_shift = (op == 4'b1000);
    dec_rtype = (op == 4'b0000) || (dec_shift && (ext == 4'b0100 || ext == 4'b0110));
    op_code   = dec_rtype ? ext : op;
    dec_alu   = (op_code[3:2] == 2'b00) ? {1'b0, op_code[1:0]} : {op_code[3], 2'b00};
    dec_flag  = (dec_alu[1:0] == 2'b00);
    dec_copy  = (op_code == 4'b1101);
    dec_immd  = dec_flag ? {{(WIDTH-8){instr_reg[7]}}, instr_reg[7:0]}
                         : {{(WIDTH-8){1'b0}}, instr_reg[7:0]};
    case (op)
      4'b0000: dec_legal = (ext inside {4'b0001, 4'b0010, 4'b0011, 4'b0101, 4'b1001, 4'b1101});
      4'b1000: dec_legal = (ext inside {4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0100, 4'b0110});
      4'b0001, 4'b0010, 4'b0011, 4'b0101, 4'b1001, 4'b1101: dec_legal = 1'b1;
      default: dec_legal = 1'b0;
    endcase
  end

  always_comb begin
    state_next = state;
    instrReady = 1'b0;
    regWrite   = 1'b0;
    illegal    = 1'b0;
    case (state)
      IDLE: begin
        instrReady = 1'b1;
        if (instrValid) state_next = DECODE;
      end
      DECODE: begin
        if (dec_legal) begin
          state_next = EXECUTE;
        end else begin
          illegal    = !reset;
          state_next = IDLE;
        end
      end
      EXECUTE: state_next = WRITEBACK;
      WRITEBACK: begin
        regWrite   = !reset;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Control outputs load only for legal words, so a dropped encoding leaves the RF inputs untouched.
  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= IDLE;
      instr_reg        <= '0;
      srcAddr          <= '0;
      dstAddr          <= '0;
      immd             <= '0;
      rTypeInstruction <= 1'b0;
      shiftInstruction <= 1'b0;
      flagSet          <= 1'b0;
      copyInstruction  <= 1'b0;
      aluOp            <= '0;
    end else begin
      state <= state_next;
      if (state == IDLE && instrValid) instr_reg <= instruction;
      if (state == DECODE && dec_legal) begin
        srcAddr          <= instr_reg[3:0];
        dstAddr          <= instr_reg[11:8];
        immd             <= dec_immd;
        rTypeInstruction <= dec_rtype;
        shiftInstruction <= dec_shift;
        flagSet          <= dec_flag;
        copyInstruction  <= dec_copy;
        aluOp            <= dec_alu;
      end
    end
  end

endmodule
